// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment driver.
package seven_seg_pkg;

    typedef enum logic {
        DEAD = 1'b0,
        ON   = 1'b1
    } state_e;

    // Active-low segment patterns, bit order {G,F,E,D,C,B,A}.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = 7'b1111001;
    localparam logic [6:0] GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000;
    localparam logic [6:0] GLYPH_4 = 7'b0011001;
    localparam logic [6:0] GLYPH_5 = 7'b0010010;
    localparam logic [6:0] GLYPH_6 = 7'b0000010;
    localparam logic [6:0] GLYPH_7 = 7'b1111000;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0010000;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b0000011;
    localparam logic [6:0] GLYPH_C = 7'b1000110;
    localparam logic [6:0] GLYPH_D = 7'b0100001;
    localparam logic [6:0] GLYPH_E = 7'b0000110;
    localparam logic [6:0] GLYPH_F = 7'b0001110;

    // Bits needed to count up to the larger of two lengths, never below 1 bit.
    function automatic int count_width(input int len_a, input int len_b);
        int m;
        m = 2;
        if (len_a > m) m = len_a;
        if (len_b > m) m = len_b;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// Hex nibble to active-low seven-segment pattern.
module seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Every nibble value has its own glyph; the case is complete.
    always_comb begin
        unique case (nibble_i)
            4'h0: seg_o = GLYPH_0;
            4'h1: seg_o = GLYPH_1;
            4'h2: seg_o = GLYPH_2;
            4'h3: seg_o = GLYPH_3;
            4'h4: seg_o = GLYPH_4;
            4'h5: seg_o = GLYPH_5;
            4'h6: seg_o = GLYPH_6;
            4'h7: seg_o = GLYPH_7;
            4'h8: seg_o = GLYPH_8;
            4'h9: seg_o = GLYPH_9;
            4'hA: seg_o = GLYPH_A;
            4'hB: seg_o = GLYPH_B;
            4'hC: seg_o = GLYPH_C;
            4'hD: seg_o = GLYPH_D;
            4'hE: seg_o = GLYPH_E;
            4'hF: seg_o = GLYPH_F;
        endcase
    end

endmodule

// File: rtl/seven_seg_mux.sv
// Time-multiplexed seven-segment driver with dead time, per-frame input
// snapshot, blanking, decimal points and optional leading-zero suppression.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   DEAD  | all digits dark for DEAD_CYCLES clocks before each digit
//   ON    | digit idx lit (unless dark) for REFRESH_DIV clocks
//
// Output registers are loaded from the next-state values, so the pins
// always reflect the current state register exactly.
module seven_seg_mux
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 2,
    parameter int REFRESH_DIV   = 1000,
    parameter int DEAD_CYCLES   = 16,
    parameter int LZ_SUPPRESS   = 0,
    parameter int EN_ACTIVE_LOW = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [4*NUM_DIGITS-1:0]   digits,
    input  logic [NUM_DIGITS-1:0]     blank,
    input  logic [NUM_DIGITS-1:0]     dp,
    output logic [6:0]                seg,
    output logic                      dp_n,
    output logic [NUM_DIGITS-1:0]     en
);

    localparam int CW = count_width(REFRESH_DIV, DEAD_CYCLES);
    localparam int IW = count_width(NUM_DIGITS, 0);

    localparam logic [CW-1:0] ON_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] DEAD_LAST = CW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] EN_OFF =
        (EN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    state_e                    state_q, state_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      frame_end;

    logic                      snap_pending_q;
    logic                      capture;
    logic [4*NUM_DIGITS-1:0]   frame_dig_q, frame_dig_d;
    logic [NUM_DIGITS-1:0]     frame_dp_q, frame_dp_d;
    logic [NUM_DIGITS-1:0]     dark_q, dark_d;
    logic [NUM_DIGITS-1:0]     lz_mask;
    logic                      zero_run;

    logic [3:0]                nib;
    logic                      dark_sel;
    logic                      dp_sel;
    logic [NUM_DIGITS-1:0]     en_onehot;
    logic                      lit;
    logic [6:0]                dec_seg;

    logic [6:0]                seg_q, seg_d;
    logic                      dp_n_q, dp_n_d;
    logic [NUM_DIGITS-1:0]     en_q, en_d;

    // Sequencer: dead time, lit time, digit index advance.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q + CW'(1);
        frame_end = 1'b0;
        case (state_q)
            DEAD: begin
                if (DEAD_CYCLES == 0 || cnt_q == DEAD_LAST) begin
                    state_d = ON;
                    cnt_d   = '0;
                end
            end
            ON: begin
                if (cnt_q == ON_LAST) begin
                    cnt_d   = '0;
                    state_d = (DEAD_CYCLES == 0) ? ON : DEAD;
                    if (idx_q == IDX_LAST) begin
                        idx_d     = '0;
                        frame_end = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Leading-zero mask: digit i is suppressed when it and all higher digits are zero.
    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (digits[4*i +: 4] == 4'h0);
            if (LZ_SUPPRESS != 0 && i != 0) lz_mask[i] = zero_run;
        end
    end

    // Snapshot on entry to each digit-0 visit, and on the first clock after reset.
    always_comb begin
        capture     = snap_pending_q | frame_end;
        frame_dig_d = capture ? digits          : frame_dig_q;
        frame_dp_d  = capture ? dp              : frame_dp_q;
        dark_d      = capture ? (blank | lz_mask) : dark_q;
    end

    // Select the digit about to be shown from the frame being entered.
    always_comb begin
        nib       = 4'h0;
        dark_sel  = 1'b0;
        dp_sel    = 1'b0;
        en_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IW'(i) == idx_d) begin
                nib          = frame_dig_d[4*i +: 4];
                dark_sel     = dark_d[i];
                dp_sel       = frame_dp_d[i];
                en_onehot[i] = 1'b1;
            end
        end
    end

    seg_decoder u_seg_decoder (
        .nibble_i (nib),
        .seg_o    (dec_seg)
    );

    // Output values for the state being entered; dark digits keep everything off.
    always_comb begin
        lit    = (state_d == ON) && !dark_sel;
        seg_d  = lit ? dec_seg : SEG_OFF;
        dp_n_d = lit ? ~dp_sel : 1'b1;
        en_d   = EN_OFF;
        if (lit) en_d = (EN_ACTIVE_LOW != 0) ? ~en_onehot : en_onehot;
    end

    // Sequencer and frame registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= DEAD;
            idx_q          <= '0;
            cnt_q          <= '0;
            snap_pending_q <= 1'b1;
            frame_dig_q    <= '0;
            frame_dp_q     <= '0;
            dark_q         <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            snap_pending_q <= 1'b0;
            frame_dig_q    <= frame_dig_d;
            frame_dp_q     <= frame_dp_d;
            dark_q         <= dark_d;
        end
    end

    // Pin registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_q  <= SEG_OFF;
            dp_n_q <= 1'b1;
            en_q   <= EN_OFF;
        end else begin
            seg_q  <= seg_d;
            dp_n_q <= dp_n_d;
            en_q   <= en_d;
        end
    end

    assign seg  = seg_q;
    assign dp_n = dp_n_q;
    assign en   = en_q;

endmodule

// File: tb/tb_seven_seg_mux.sv
// Bench for seven_seg_mux: two 4-digit instances (with and without
// leading-zero suppression) driven from a frame table, plus a 1-digit
// degenerate instance.
`timescale 1ns/1ps
module tb_seven_seg_mux;

    localparam int N     = 4;
    localparam int P     = 5;
    localparam int FRAME = N * P;
    localparam logic [6:0] OFF = 7'h7F;

    localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100, G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001, G5 = 7'b0010010, G6 = 7'b0000010, G7 = 7'b1111000;
    localparam logic [6:0] G8 = 7'b0000000, G9 = 7'b0010000, GA = 7'b0001000, GB = 7'b0000011;
    localparam logic [6:0] GC = 7'b1000110, GD = 7'b0100001, GE = 7'b0000110, GF = 7'b0001110;

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  blank;
        logic [3:0]  dp;
        logic [27:0] glyphs;      // {d3,d2,d1,d0}
        logic [3:0]  lit_a;       // digits lit without suppression
        logic [3:0]  lit_b;       // digits lit with suppression
        logic        mid_chg;
        logic [15:0] mid_digits;
    } vec_t;

    typedef struct packed {
        logic [3:0] en_a;
        logic [6:0] seg_a;
        logic       dpn_a;
        logic [3:0] en_b;
        logic [6:0] seg_b;
        logic       dpn_b;
        logic [7:0] tag_r;
        logic [7:0] tag_p;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  blank = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  digits_c = '0;
    logic        blank_c = 1'b0;
    logic        dp_c = 1'b1;

    logic [6:0]  seg_a, seg_b, seg_c;
    logic        dpn_a, dpn_b, dpn_c;
    logic [3:0]  en_a, en_b;
    logic        en_c;

    vec_t        vec [8];
    exp_t        sb [$];
    logic [6:0]  sb_c [$];
    logic [3:0]  cv [5];
    logic [6:0]  cg [5];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seven_seg_mux #(.NUM_DIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(1),
                    .LZ_SUPPRESS(0), .EN_ACTIVE_LOW(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .digits(digits), .blank(blank), .dp(dp),
        .seg(seg_a), .dp_n(dpn_a), .en(en_a));

    seven_seg_mux #(.NUM_DIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(1),
                    .LZ_SUPPRESS(1), .EN_ACTIVE_LOW(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .digits(digits), .blank(blank), .dp(dp),
        .seg(seg_b), .dp_n(dpn_b), .en(en_b));

    seven_seg_mux #(.NUM_DIGITS(1), .REFRESH_DIV(1), .DEAD_CYCLES(0),
                    .LZ_SUPPRESS(0), .EN_ACTIVE_LOW(1)) dut_c (
        .clk(clk), .reset_n(reset_n), .digits(digits_c), .blank(blank_c), .dp(dp_c),
        .seg(seg_c), .dp_n(dpn_c), .en(en_c));

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive a frame's inputs and queue the expected outputs for its 20 clocks.
    task automatic apply(input int r);
        exp_t e;
        digits = vec[r].digits;
        blank  = vec[r].blank;
        dp     = vec[r].dp;
        for (int p = 0; p < FRAME; p++) begin
            int d;
            logic on, la, lb;
            logic [6:0] g;
            d  = p / P;
            on = (p % P) != 0;
            g  = vec[r].glyphs[7*d +: 7];
            la = on && vec[r].lit_a[d];
            lb = on && vec[r].lit_b[d];
            e.en_a  = la ? ~(4'b0001 << d) : 4'hF;
            e.seg_a = la ? g : OFF;
            e.dpn_a = la ? ~vec[r].dp[d] : 1'b1;
            e.en_b  = lb ? ~(4'b0001 << d) : 4'hF;
            e.seg_b = lb ? g : OFF;
            e.dpn_b = lb ? ~vec[r].dp[d] : 1'b1;
            e.tag_r = 8'(r);
            e.tag_p = 8'(p);
            sb.push_back(e);
        end
    endtask

    task automatic check_cycle();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected at least 1");
        end else begin
            e = sb.pop_front();
            chk($sformatf("r%0d p%0d a.en",  e.tag_r, e.tag_p), 16'(en_a),  16'(e.en_a));
            chk($sformatf("r%0d p%0d a.seg", e.tag_r, e.tag_p), 16'(seg_a), 16'(e.seg_a));
            chk($sformatf("r%0d p%0d a.dpn", e.tag_r, e.tag_p), 16'(dpn_a), 16'(e.dpn_a));
            chk($sformatf("r%0d p%0d b.en",  e.tag_r, e.tag_p), 16'(en_b),  16'(e.en_b));
            chk($sformatf("r%0d p%0d b.seg", e.tag_r, e.tag_p), 16'(seg_b), 16'(e.seg_b));
            chk($sformatf("r%0d p%0d b.dpn", e.tag_r, e.tag_p), 16'(dpn_b), 16'(e.dpn_b));
        end
    endtask

    // Caller has applied vec[first] at the negedge of frame cycle 0.
    task automatic run_table(input int first, input int last);
        for (int r = first; r <= last; r++) begin
            for (int p = 0; p < FRAME; p++) begin
                if (r == first && p == 0) #1;
                else @(negedge clk);
                check_cycle();
                if (p == 7 && vec[r].mid_chg) digits = vec[r].mid_digits;
                if (p == FRAME - 1 && r < last) apply(r + 1);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " a.en"},  16'(en_a),  16'h000F);
        chk({tag, " a.seg"}, 16'(seg_a), 16'(OFF));
        chk({tag, " a.dpn"}, 16'(dpn_a), 16'h0001);
        chk({tag, " b.en"},  16'(en_b),  16'h000F);
        chk({tag, " b.seg"}, 16'(seg_b), 16'(OFF));
        chk({tag, " c.en"},  16'(en_c),  16'h0001);
        chk({tag, " c.seg"}, 16'(seg_c), 16'(OFF));
        chk({tag, " c.dpn"}, 16'(dpn_c), 16'h0001);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //              digits    blank  dp     glyphs {d3,d2,d1,d0}   lit_a  lit_b  mid   mid_digits
        vec[0] = '{16'h12AF, 4'h0, 4'h0, {G1, G2, GA, GF}, 4'hF, 4'hF, 1'b1, 16'h3456};
        vec[1] = '{16'h3456, 4'h0, 4'h0, {G3, G4, G5, G6}, 4'hF, 4'hF, 1'b0, 16'h0000};
        vec[2] = '{16'h0050, 4'h0, 4'h0, {G0, G0, G5, G0}, 4'hF, 4'h3, 1'b0, 16'h0000};
        vec[3] = '{16'h0000, 4'h0, 4'h0, {G0, G0, G0, G0}, 4'hF, 4'h1, 1'b0, 16'h0000};
        vec[4] = '{16'h8888, 4'h2, 4'h3, {G8, G8, G8, G8}, 4'hD, 4'hD, 1'b0, 16'h0000};
        vec[5] = '{16'h00C9, 4'h0, 4'hC, {G0, G0, GC, G9}, 4'hF, 4'h3, 1'b0, 16'h0000};
        vec[6] = '{16'h7BDE, 4'h8, 4'h4, {G7, GB, GD, GE}, 4'h7, 4'h7, 1'b0, 16'h0000};
        vec[7] = '{16'h0800, 4'h1, 4'h1, {G0, G8, G0, G0}, 4'hE, 4'h6, 1'b0, 16'h0000};

        cv = '{4'h0, 4'hA, 4'h5, 4'hF, 4'h3};
        cg = '{G0, GA, G5, GF, G3};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        reset_n = 1'b1;
        apply(0);
        run_table(0, 7);

        // Drop reset in the middle of digit 2's lit time.
        repeat (13) @(negedge clk);
        chk("pre_reset a.en", 16'(en_a), 16'h000B);
        chk("pre_reset b.en", 16'(en_b), 16'h000B);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        check_reset_outputs("held_reset");
        reset_n = 1'b1;
        apply(0);
        run_table(0, 1);

        // Single-digit instance: always enabled, follows input within two clocks.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            digits_c = cv[i];
            sb_c.push_back(cg[i]);
            @(negedge clk);
            chk($sformatf("c%0d en_mid", i), 16'(en_c), 16'h0000);
            @(negedge clk);
            chk($sformatf("c%0d en", i), 16'(en_c), 16'h0000);
            chk($sformatf("c%0d dpn", i), 16'(dpn_c), 16'h0000);
            if (sb_c.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL c_scoreboard_empty: got 0 entries expected 1");
            end else begin
                chk($sformatf("c%0d seg", i), 16'(seg_c), 16'(sb_c.pop_front()));
            end
        end

        chk("sb_leftover", 16'(sb.size()), 16'h0000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seven_seg_mux.md
Name: seven_seg_mux

Overview:
Time-multiplexed driver for a common-segment bank of NUM_DIGITS seven-segment digits. It cycles one digit enable at a time and decodes that digit's hex nibble to active-low segments. A programmable dead time between digits suppresses ghosting. It also provides per-digit blanking, per-digit decimal points, optional leading-zero suppression, and a per-frame input snapshot so the display never tears. It sits between the datapath and the board pins in every lab top level that drives multi-digit displays.

Parameters:
NUM_DIGITS, 2, number of multiplexed digits; 1..8.
REFRESH_DIV, 1000, clocks each digit is lit per visit; >=1.
DEAD_CYCLES, 16, clocks all digits are dark before each digit is lit; 0 allowed.
LZ_SUPPRESS, 0, 1 enables leading-zero blanking.
EN_ACTIVE_LOW, 1, polarity of the en outputs (1 = low enables a digit, for PNP drivers).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
digits  in  4*NUM_DIGITS  packed hex nibbles; digit i = digits[4i+3:4i]; digit 0 is least significant
blank  in  NUM_DIGITS  1 forces digit i dark
dp  in  NUM_DIGITS  1 lights the decimal point of digit i
seg  out  7  active-low segments; seg[0]=A .. seg[6]=G
dp_n  out  1  active-low decimal point
en  out  NUM_DIGITS  digit enables, polarity per EN_ACTIVE_LOW

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, reset_n.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset value while reset_n is low, asserted at any time including mid-frame:
  - seg=7'b1111111, dp_n=1, en all inactive.
  - state=DEAD, idx=0, cnt=0.
  - Frame registers cleared to 0.
  - snap_pending=1.
- State machine: DEAD and ON.
  - DEAD: en all inactive, seg=7'h7F, dp_n=1. Lasts DEAD_CYCLES clocks, then goes to ON with cnt=0.
  - If DEAD_CYCLES=0, the DEAD state is never occupied; ON follows ON directly.
  - ON: en[idx] active, all others inactive. seg=decode(frame_digit[idx]) and dp_n=~frame_dp[idx], unless the digit is dark. Lasts REFRESH_DIV clocks.
  - At the end of ON: idx increments, wrapping NUM_DIGITS-1 -> 0. The next state is DEAD, or ON if DEAD_CYCLES=0.
- Timing:
  - Digit period P = DEAD_CYCLES + REFRESH_DIV.
  - Frame period = NUM_DIGITS * P.
  - The duty cycle of each digit is exact, with no off-by-one.
- Snapshot:
  - digits, blank and dp are captured into frame registers on the first clock of each digit-0 visit.
  - The first such clock after reset release also captures.
  - Inputs that change mid-frame take effect only at the next frame.
- Dark digit: blank[i], or leading-zero suppression of digit i. Leading-zero suppression applies when LZ_SUPPRESS=1, i!=0, and every frame digit from NUM_DIGITS-1 down to i equals 0.
  - Blanking and suppression are evaluated at snapshot time.
  - During ON for a dark digit: en stays inactive, seg=7'h7F, dp_n=1.
  - A dp request on a suppressed digit is ignored; blank has priority over dp.
- Decode table (active low, 0 = lit). The code covers all 16 values with no default glyph:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Widths:
  - cnt is sized $clog2(max(REFRESH_DIV, DEAD_CYCLES, 2)).
  - idx is sized $clog2(max(NUM_DIGITS, 2)).
  - With NUM_DIGITS=1, idx is constant 0 and the snapshot occurs every P clocks.

Decomposition:
- seven_seg_pkg:
  - state enum (DEAD, ON).
  - SEG_OFF=7'h7F.
  - The 16 glyph constants.
  - A function computing the count-width.
- Sub-module seg_decoder: combinational nibble -> active-low seg, built from the package constants. It is instantiated once, on the idx-selected frame digit, ahead of the output register.

Test Plan:
Default bench: NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1, giving P=5 and frame=20.
1. Reset: drop reset_n mid-ON of digit 2 -> same cycle en=4'b1111, seg=7'h7F, dp_n=1. Release -> 1 dark clock, then digit 0 lit.
2. Scan: digits=16'h12AF -> en sequence 1111,1110x4, 1111,1101x4, 1111,1011x4, 1111,0111x4 with seg 0001110, 0001000, 0100100, 1111001. The sequence repeats every 20 clocks.
3. Tearing: change digits to 16'h3456 during digit-1 ON -> remaining digits 2 and 3 still show 2 and 1. From the next digit-0 visit, digits show 6,5,4,3.
4. Leading-zero suppression (LZ_SUPPRESS=1):
   - digits=16'h0050 -> digits 3 and 2 dark with en inactive; digit 1 shows 5; digit 0 shows 0 (1000000).
   - digits=16'h0000 -> only digit 0 lit.
5. Blank/dp: blank=4'b0010, dp=4'b0011, digits=16'h8888 -> digit 1 dark with dp_n=1; digit 0 shows seg=0000000 with dp_n=0; digits 2 and 3 show dp_n=1.
6. Degenerate case: NUM_DIGITS=1, DEAD_CYCLES=0, REFRESH_DIV=1 -> en constantly active. seg follows a digits change within 2 clocks (snapshot, then output register).
